wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data width of both requester payloads and of the write port.
REQ-002 Parameter AW, default 5: register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 hold  input  1  pipeline stall; while 1, no grant is issued.
REQ-006 valid0  input  1  requester 0 (ALU result path) has a write pending.
REQ-007 rd0  input  AW  requester 0 destination register.
REQ-008 data0  input  WIDTH  requester 0 write data.
REQ-009 ready0  output  1  requester 0 granted this cycle; combinational.
REQ-010 valid1  input  1  requester 1 (load data path) has a write pending.
REQ-011 rd1  input  AW  requester 1 destination register.
REQ-012 data1  input  WIDTH  requester 1 write data.
REQ-013 ready1  output  1  requester 1 granted this cycle; combinational.
REQ-014 wr_en  output  1  register-file write strobe; registered.
REQ-015 wr_addr  output  AW  register-file write address; registered.
REQ-016 wr_data  output  WIDTH  register-file write data; registered.
REQ-017 sel  output  1  index of the source driving the write port (0 = data0, 1 = data1); registered, drives the writeback mux select.
REQ-018 conflicts  output  16  saturating count of cycles with contention.

Function
REQ-019 A transfer on requester i SHALL complete in a cycle where valid_i = 1 and ready_i = 1.
REQ-020 ready0/ready1 SHALL be mutually exclusive and SHALL both be 0 when hold = 1 or rst = 1.
REQ-021 Only valid0 = 1 (hold = 0): ready0 = 1; only valid1 = 1: ready1 = 1; neither: both 0.
REQ-022 Both valid (hold = 0): the grant SHALL go to the requester not granted most recently, tracked by a 1-bit last_grant register.
REQ-023 last_grant SHALL update to the granted index only in a cycle with a completed transfer; it SHALL be unchanged otherwise, including during hold.
REQ-024 Latency: a transfer completed in cycle N SHALL appear on wr_addr/wr_data/sel in cycle N+1, with wr_en = 1 unless rd = 0.
REQ-025 A transfer with rd = 0 SHALL be accepted (ready = 1) but SHALL produce wr_en = 0 in cycle N+1; wr_addr, wr_data and sel are still loaded.
REQ-026 In a cycle with no completed transfer, wr_en SHALL be 0 in the next cycle; wr_addr, wr_data and sel SHALL hold their previous values.
REQ-027 Requesters SHALL keep valid, rd and data stable until ready; the arbiter does not check this, and a dropped valid before grant is legal and loses nothing.
REQ-028 conflicts SHALL increment by 1 in each cycle with valid0 = valid1 = 1 and hold = 0, and SHALL saturate at 16'hFFFF without wrapping.
REQ-029 No state machine beyond last_grant, the output registers and conflicts; the throughput is one write per cycle.

Reset
REQ-030 With rst = 1 at a rising edge: wr_en = 0, wr_addr = 0, wr_data = 0, sel = 0, conflicts = 0, last_grant = 1 (so the first contention grants requester 0).
REQ-031 rst SHALL override hold and all valids. A transfer presented in the same cycle as rst SHALL NOT complete, and no write from it SHALL appear after reset.
REQ-032 Reset asserted mid-stream SHALL discard any registered write. wr_en SHALL be 0 in the cycle after the reset edge.

Verification
REQ-033 Single source: valid0 = 1, rd0 = 5, data0 = 32'h00000001 for one cycle -> ready0 = 1 that cycle; next cycle wr_en = 1, wr_addr = 5, wr_data = 1, sel = 0.
REQ-034 Contention after reset: valid0 = valid1 = 1 held for 4 cycles (rd0 = 3, rd1 = 4, data1 = 32'hFFFFFFFE) -> grants 0,1,0,1; sel sequence 0,1,0,1 one cycle later; conflicts = 4.
REQ-035 x0 discard: valid1 = 1, rd1 = 0, data1 = 32'h00000002 -> ready1 = 1; next cycle wr_en = 0, wr_data = 2, sel = 1.
REQ-036 Hold: valid0 = valid1 = 1 with hold = 1 for 3 cycles -> ready0 = ready1 = 0, wr_en = 0, conflicts unchanged. Releasing hold -> the grant goes to the requester opposite last_grant.
REQ-037 Reset mid-operation: rst = 1 in the cycle after a granted transfer -> wr_en = 0 after the edge, conflicts = 0, and the next contention grants requester 0.
REQ-038 Saturation: force 65 540 contention cycles -> conflicts stops at 16'hFFFF.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Two-requester writeback arbiter with round-robin tie-break,
//               registered register-file write port and contention counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             valid0,
  input  logic [AW-1:0]    rd0,
  input  logic [WIDTH-1:0] data0,
  output logic             ready0,
  input  logic             valid1,
  input  logic [AW-1:0]    rd1,
  input  logic [WIDTH-1:0] data1,
  output logic             ready1,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             sel,
  output logic [15:0]      conflicts
);

  localparam logic [15:0] c_CONF_MAX = 16'hFFFF;

  logic             r_last_grant;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic             r_sel;
  logic [15:0]      r_conflicts;

  logic             w_open;
  logic             w_contend;
  logic             w_gnt0;
  logic             w_gnt1;
  logic [AW-1:0]    w_rd;
  logic [WIDTH-1:0] w_data;

  // On contention, the requester not granted most recently wins.
  assign w_open    = !rst && !hold;
  assign w_contend = valid0 && valid1 && !hold;
  assign w_gnt0    = w_open && valid0 && (!valid1 || r_last_grant);
  assign w_gnt1    = w_open && valid1 && (!valid0 || !r_last_grant);
  assign w_rd      = w_gnt1 ? rd1   : rd0;
  assign w_data    = w_gnt1 ? data1 : data0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_sel        <= 1'b0;
      r_conflicts  <= '0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        // Writes to register 0 are accepted but never strobed.
        r_last_grant <= w_gnt1;
        r_wr_en      <= (w_rd != '0);
        r_wr_addr    <= w_rd;
        r_wr_data    <= w_data;
        r_sel        <= w_gnt1;
      end else begin
        r_wr_en      <= 1'b0;
      end
      if (w_contend && (r_conflicts != c_CONF_MAX)) begin
        r_conflicts <= r_conflicts + 16'd1;
      end
    end
  end

  assign ready0    = w_gnt0;
  assign ready1    = w_gnt1;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign sel       = r_sel;
  assign conflicts = r_conflicts;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        valid0;
  logic [4:0]  rd0;
  logic [31:0] data0;
  logic        ready0;
  logic        valid1;
  logic [4:0]  rd1;
  logic [31:0] data1;
  logic        ready1;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sel;
  logic [15:0] conflicts;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(.WIDTH(32), .AW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .valid0   (valid0),
    .rd0      (rd0),
    .data0    (data0),
    .ready0   (ready0),
    .valid1   (valid1),
    .rd1      (rd1),
    .data1    (data1),
    .ready1   (ready1),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sel      (sel),
    .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then driven 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    valid0 = 1'b1; rd0 = 5'd7; data0 = 32'hDEAD0007;
    valid1 = 1'b0; rd1 = 5'd0; data1 = 32'h0;
    #1;
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    tick();
    tick();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    chk("rst_conflicts", {16'd0, conflicts}, 32'd0);
    rst = 1'b0; valid0 = 1'b0;
    tick();
    chk("rst_no_write", {31'd0, wr_en}, 32'd0);

    // Single source
    valid0 = 1'b1; rd0 = 5'd5; data0 = 32'h00000001;
    #1;
    chk("single_ready0", {31'd0, ready0}, 32'd1);
    chk("single_ready1", {31'd0, ready1}, 32'd0);
    tick();
    valid0 = 1'b0;
    chk("single_wr_en", {31'd0, wr_en}, 32'd1);
    chk("single_wr_addr", {27'd0, wr_addr}, 32'd5);
    chk("single_wr_data", wr_data, 32'd1);
    chk("single_sel", {31'd0, sel}, 32'd0);
    tick();
    chk("idle_wr_en", {31'd0, wr_en}, 32'd0);
    chk("idle_wr_addr_held", {27'd0, wr_addr}, 32'd5);

    // Contention after reset: 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid0 = 1'b1; rd0 = 5'd3; data0 = 32'h00000003;
    valid1 = 1'b1; rd1 = 5'd4; data1 = 32'hFFFFFFFE;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_ready0", {31'd0, ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_ready1", {31'd0, ready1}, (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("cont_sel", {31'd0, sel}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("cont_wr_addr", {27'd0, wr_addr}, (k % 2 == 0) ? 32'd3 : 32'd4);
      chk("cont_wr_data", wr_data, (k % 2 == 0) ? 32'h00000003 : 32'hFFFFFFFE);
      chk("cont_wr_en", {31'd0, wr_en}, 32'd1);
    end
    valid0 = 1'b0; valid1 = 1'b0;
    chk("cont_conflicts", {16'd0, conflicts}, 32'd4);

    // Write to register 0 is accepted but not strobed
    valid1 = 1'b1; rd1 = 5'd0; data1 = 32'h00000002;
    #1;
    chk("x0_ready1", {31'd0, ready1}, 32'd1);
    tick();
    valid1 = 1'b0;
    chk("x0_wr_en", {31'd0, wr_en}, 32'd0);
    chk("x0_wr_data", wr_data, 32'd2);
    chk("x0_sel", {31'd0, sel}, 32'd1);

    // Hold blocks grants and counting; last_grant is 1 here
    hold = 1'b1;
    valid0 = 1'b1; rd0 = 5'd9; data0 = 32'h00000009;
    valid1 = 1'b1; rd1 = 5'd10; data1 = 32'h0000000A;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_ready0", {31'd0, ready0}, 32'd0);
      chk("hold_ready1", {31'd0, ready1}, 32'd0);
      tick();
      chk("hold_wr_en", {31'd0, wr_en}, 32'd0);
      chk("hold_conflicts", {16'd0, conflicts}, 32'd4);
    end
    hold = 1'b0;
    #1;
    chk("unhold_ready0", {31'd0, ready0}, 32'd1);
    chk("unhold_ready1", {31'd0, ready1}, 32'd0);
    tick();
    chk("unhold_sel", {31'd0, sel}, 32'd0);
    chk("unhold_wr_addr", {27'd0, wr_addr}, 32'd9);
    chk("unhold_conflicts", {16'd0, conflicts}, 32'd5);

    // Reset mid-operation; last_grant is 0 now, reset must restore 1
    rst = 1'b1;
    #1;
    chk("midrst_ready0", {31'd0, ready0}, 32'd0);
    chk("midrst_ready1", {31'd0, ready1}, 32'd0);
    tick();
    rst = 1'b0;
    chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("midrst_conflicts", {16'd0, conflicts}, 32'd0);
    #1;
    chk("midrst_grant0", {31'd0, ready0}, 32'd1);
    chk("midrst_no_grant1", {31'd0, ready1}, 32'd0);

    // Saturation: counter began from 0 at this contention cycle
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, conflicts}, 32'h0000FFFE);
    tick();
    chk("sat_ffff", {16'd0, conflicts}, 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, conflicts}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
